// File: rtl/matrix_addsub_pipe.sv
// Pipelined LANES x W element-wise add/sub with signed overflow flags; 2-stage latency, stalls on out_ready low.
// Define MATRIX_ADDSUB_SAT_EN to saturate overflowing lanes instead of wrapping.
module matrix_addsub_pipe #(
  parameter int W     = 16,
  parameter int LANES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               op_sub,
  input  logic [LANES*W-1:0] a_vec,
  input  logic [LANES*W-1:0] b_vec,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_vec,
  output logic [LANES-1:0]   out_ovf,
  output logic [LANES-1:0]   sticky_ovf,
  input  logic               clr_ovf
);

  localparam int VW = LANES * W;

  logic             s1_valid;
  logic [VW-1:0]    s1_a;
  logic [VW-1:0]    s1_b;
  logic             s1_sub;
  logic             s2_adv;
  logic             out_xfer;
  logic [VW-1:0]    nxt_vec;
  logic [LANES-1:0] nxt_ovf;
  logic [W-1:0]     la;
  logic [W-1:0]     lb;
  logic [W-1:0]     lr;
  logic             lov;

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;
  assign out_xfer = out_valid && out_ready;

  // Lane slice j maps straight onto ovf bit j, so lane 0 lands in the MSBs of both.
  always_comb begin
    nxt_vec = '0;
    nxt_ovf = '0;
    la      = '0;
    lb      = '0;
    lr      = '0;
    lov     = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      la  = s1_a[j*W +: W];
      lb  = s1_b[j*W +: W];
      lr  = s1_sub ? (la - lb) : (la + lb);
      lov = s1_sub ? ((la[W-1] != lb[W-1]) && (lr[W-1] != la[W-1]))
                   : ((la[W-1] == lb[W-1]) && (lr[W-1] != la[W-1]));
`ifdef MATRIX_ADDSUB_SAT_EN
      // On overflow the true result always carries the sign of a.
      if (lov) lr = la[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
      nxt_vec[j*W +: W] = lr;
      nxt_ovf[j]        = lov;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_sub   <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_a   <= a_vec;
        s1_b   <= b_vec;
        s1_sub <= op_sub;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_vec   <= '0;
      out_ovf   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_vec <= nxt_vec;
        out_ovf <= nxt_ovf;
      end
    end
  end

  // A clear coinciding with a transfer keeps that transfer's events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= '0;
    end else if (clr_ovf) begin
      sticky_ovf <= out_xfer ? out_ovf : '0;
    end else if (out_xfer) begin
      sticky_ovf <= sticky_ovf | out_ovf;
    end
  end

endmodule

// File: tb/tb_matrix_addsub_pipe.sv
// Directed self-checking bench for matrix_addsub_pipe at W=16, LANES=16.
module tb_matrix_addsub_pipe;

  localparam int W     = 16;
  localparam int LANES = 16;
  localparam int VW    = W * LANES;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic          op_sub;
  logic [VW-1:0] a_vec;
  logic [VW-1:0] b_vec;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_vec;
  logic [LANES-1:0] out_ovf;
  logic [LANES-1:0] sticky_ovf;
  logic          clr_ovf;

  int n_chk  = 0;
  int n_fail = 0;

  matrix_addsub_pipe #(.W(W), .LANES(LANES)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_sub     (op_sub),
    .a_vec      (a_vec),
    .b_vec      (b_vec),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_vec    (out_vec),
    .out_ovf    (out_ovf),
    .sticky_ovf (sticky_ovf),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] rep(input logic [W-1:0] v);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*W +: W] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] one(input int lane, input logic [W-1:0] v);
    logic [VW-1:0] r;
    r = '0;
    r[(LANES-1-lane)*W +: W] = v;
    return r;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive one beat, then wait until its result is visible on the outputs.
  task automatic beat(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic sub);
    in_valid = 1'b1;
    a_vec    = a;
    b_vec    = b;
    op_sub   = sub;
    cyc();
    in_valid = 1'b0;
    cyc();
  endtask

  logic [W-1:0]  exp2, exp3, exp5;
  logic [W-1:0]  bp_exp [5];
  logic [VW-1:0] hold;
  bit            have_hold;
  int            sent, got;

  initial begin
`ifdef MATRIX_ADDSUB_SAT_EN
    exp2 = 16'h7FFF; exp3 = 16'h8000; exp5 = 16'h7FFF;
`else
    exp2 = 16'h8000; exp3 = 16'h7FFF; exp5 = 16'hFFFE;
`endif
    bp_exp[0] = 16'h1212; bp_exp[1] = 16'h2323; bp_exp[2] = 16'h3434;
    bp_exp[3] = 16'h4545; bp_exp[4] = 16'h5656;

    rst_n = 1'b0; in_valid = 1'b0; op_sub = 1'b0; a_vec = '0; b_vec = '0;
    out_ready = 1'b1; clr_ovf = 1'b0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_vec", out_vec, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_sticky", sticky_ovf, 0);
    #5 rst_n = 1'b1;
    cyc();

    // 1: single subtract beat, latency and one-cycle valid
    in_valid = 1'b1; a_vec = rep(16'h0005); b_vec = rep(16'h0003); op_sub = 1'b1;
    #1 chk("t1_in_ready", in_ready, 1);
    cyc();
    in_valid = 1'b0;
    chk("t1_not_yet", out_valid, 0);
    cyc();
    chk("t1_valid", out_valid, 1);
    chk("t1_vec", out_vec, rep(16'h0002));
    chk("t1_ovf", out_ovf, 0);
    cyc();
    chk("t1_valid_drop", out_valid, 0);

    // 2: add overflow on lane 0
    beat(one(0, 16'h7FFF), one(0, 16'h0001), 1'b0);
    chk("t2_vec", out_vec, one(0, exp2));
    chk("t2_ovf", out_ovf, 16'h8000);
    cyc();
    chk("t2_sticky", sticky_ovf, 16'h8000);

    // 3: sub overflow on the last lane
    beat(one(LANES-1, 16'h8000), one(LANES-1, 16'h0001), 1'b1);
    chk("t3_vec", out_vec, one(LANES-1, exp3));
    chk("t3_ovf", out_ovf, 16'h0001);
    cyc();
    chk("t3_sticky", sticky_ovf, 16'h8001);

    // 4: five beats against four stalled cycles
    sent = 0; got = 0; have_hold = 0; out_ready = 1'b0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (c == 4) begin
        chk("t4_accepted", sent, 2);
        chk("t4_in_ready_low", in_ready, 0);
      end
      out_ready = (c >= 4);
      in_valid  = (sent < 5);
      a_vec     = rep(16'h1111 * W'(sent + 1));
      b_vec     = rep(16'h0101);
      op_sub    = 1'b0;
      #1;
      if (out_valid && !out_ready) begin
        if (have_hold) chk("t4_hold", out_vec, hold);
        hold = out_vec;
        have_hold = 1;
      end
      if (out_valid && out_ready) begin
        chk("t4_out", out_vec, rep(bp_exp[got]));
        got++;
      end
      if (in_valid && in_ready) sent++;
      cyc();
    end
    in_valid = 1'b0;
    chk("t4_count", got, 5);
    #1 chk("t4_no_dup", out_valid, 0);
    cyc();

    // 5: clear coinciding with an overflowing transfer, then clear alone
    beat(one(2, 16'h7FFF), one(2, 16'h7FFF), 1'b0);
    clr_ovf = 1'b1;
    chk("t5_vec", out_vec, one(2, exp5));
    chk("t5_ovf", out_ovf, 16'h2000);
    cyc();
    clr_ovf = 1'b0;
    chk("t5_sticky_clr_xfer", sticky_ovf, 16'h2000);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    chk("t5_sticky_clr", sticky_ovf, 0);

    // 6: asynchronous reset with both stages full
    out_ready = 1'b0;
    in_valid = 1'b1; a_vec = rep(16'h1111); b_vec = rep(16'h0001); op_sub = 1'b0;
    cyc();
    a_vec = rep(16'h2222);
    cyc();
    in_valid = 1'b0;
    chk("t6_full_valid", out_valid, 1);
    #1 chk("t6_full_in_ready", in_ready, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_vec", out_vec, 0);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    #1 chk("t6_in_ready", in_ready, 1);
    cyc();
    chk("t6_no_stale_a", out_valid, 0);
    cyc();
    chk("t6_no_stale_b", out_valid, 0);
    beat(rep(16'h1234), rep(16'h0234), 1'b1);
    chk("t6_valid", out_valid, 1);
    chk("t6_vec", out_vec, rep(16'h1000));
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/matrix_addsub_pipe.md
Name: matrix_addsub_pipe

Overview:
Parametrised, pipelined successor of the 16-lane matrix subtractor. Performs LANES independent element-wise operations (A+B or A-B, selected per beat) on packed W-bit lanes. Uses valid/ready streaming handshakes and a 2-stage pipeline. Reports signed overflow per lane, both per beat and as a sticky flag. Sits between the matrix operand fetch and the result writeback in the matrix datapath.

Parameters:
W, 16, lane width in bits (>=2)
LANES, 16, number of lanes per beat (>=1)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept a beat
op_sub  input  1  0 = add, 1 = subtract; sampled with the beat
a_vec  input  LANES*W  packed operand A; lane 0 in [LANES*W-1 -: W], lane LANES-1 in [W-1:0]
b_vec  input  LANES*W  packed operand B; same packing as a_vec
out_valid  output  1  result beat valid
out_ready  input  1  downstream accepts the result
out_vec  output  LANES*W  packed results; same lane packing as a_vec
out_ovf  output  LANES  per-lane signed overflow for the current out_vec; bit i = lane i (MSB = lane 0)
sticky_ovf  output  LANES  accumulated per-lane overflow
clr_ovf  input  1  synchronous clear of sticky_ovf

Behaviour:
- Reset (rst_n low, async): s1_valid=0, s2_valid=0, out_valid=0, out_vec=0, out_ovf=0, sticky_ovf=0. Data registers are also cleared.
- Stage 1 registers a_vec, b_vec and op_sub. Stage 2 computes the results and drives out_vec, out_ovf and out_valid directly from registers.
- s2_adv = !s2_valid || out_ready.
- in_ready = !s1_valid || s2_adv. This is combinational from out_ready; no skid buffer.
- Input accept: in_valid && in_ready. Output transfer: out_valid && out_ready.
- Latency: a beat accepted at edge N appears on out_vec after edge N+1 (valid for 1 cycle minimum). With out_ready held high, throughput is 1 beat/cycle and there are no bubbles.
- Stall: while out_valid && !out_ready, out_vec, out_ovf and out_valid hold stable. Stage 1 holds if it is full. in_ready drops only when both stages are full.
- Simultaneous output transfer and stage-1 advance in the same cycle: stage 2 reloads from stage 1 with no bubble.
- Inputs are ignored when in_valid=0 or in_ready=0. op_sub and data are don't-care outside accepted beats.
- Arithmetic: per lane, r = op_sub ? a-b : a+b, modulo 2^W (wrap), two's complement.
- Overflow, operands treated as signed:
  - add: sign(a)==sign(b) && sign(r)!=sign(a)
  - sub: sign(a)!=sign(b) && sign(r)!=sign(a)
- sticky_ovf: on each output transfer, sticky_ovf |= out_ovf. clr_ovf=1 clears it.
- clr_ovf coincident with an output transfer: sticky_ovf = out_ovf of that transfer. A new event is never lost.
- Reset mid-stream: all in-flight beats are discarded and no output transfer occurs. After release, the block accepts on the first cycle.

Optional Feature:
Macro MATRIX_ADDSUB_SAT_EN.
- Defined: a lane with overflow outputs a signed-saturated value: 0x7FFF if the true result is positive, 0x8000 if negative (W=16; generally max/min signed W-bit). out_ovf still reports the overflow.
- Undefined: results wrap modulo 2^W. Interface and latency are identical in both builds.

Test Plan:
1. Reset then a single beat, out_ready=1: all lanes a=0x0005, b=0x0003, op_sub=1 -> out_vec lanes 0x0002 two cycles after accept; out_ovf=0; out_valid high 1 cycle.
2. Add overflow, lane 0: a=0x7FFF, b=0x0001, op_sub=0 -> lane 0 = 0x8000 (wrap) or 0x7FFF (SAT_EN); out_ovf[LANES-1]=1; sticky_ovf[LANES-1]=1 afterwards.
3. Sub overflow, last lane: a=0x8000, b=0x0001, op_sub=1 -> lane LANES-1 = 0x7FFF (wrap) or 0x8000 (SAT_EN); out_ovf[0]=1.
4. Backpressure: stream 5 beats with in_valid=1 and out_ready=0 for 4 cycles -> exactly 2 beats accepted and in_ready=0. Once out_ready=1, the 5 results arrive in order with no loss or duplication, and out_vec holds stable while stalled.
5. clr_ovf asserted in the same cycle as an overflowing output transfer on lane 2 -> sticky_ovf = only that lane's bit. clr_ovf alone -> sticky_ovf = 0.
6. Assert rst_n low with both stages full -> out_valid=0 immediately (async). After release: in_ready=1, no stale output, and the next beat computes correctly.
